// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sound_pkg
//  Description : Shared types and constants for the sound arbiter: FSM state
//                encoding, sound-event indices and the beep pattern table.
//  Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

    localparam int unsigned NUM_EV = 4;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Sound-event indices; a higher index means a higher priority
    localparam logic [1:0] EV_MOVE = 2'd0;
    localparam logic [1:0] EV_DROP = 2'd1;
    localparam logic [1:0] EV_LINE = 2'd2;
    localparam logic [1:0] EV_OVER = 2'd3;

    // One beep pattern: number of beeps, tone length and gap length in ms
    typedef struct packed {
        logic [2:0] beeps;
        logic [9:0] on_ms;
        logic [9:0] gap_ms;
    } pattern_t;

    localparam pattern_t PAT_MOVE = '{beeps: 3'd1, on_ms: 10'd20,  gap_ms: 10'd20};
    localparam pattern_t PAT_DROP = '{beeps: 3'd1, on_ms: 10'd60,  gap_ms: 10'd40};
    localparam pattern_t PAT_LINE = '{beeps: 3'd3, on_ms: 10'd100, gap_ms: 10'd50};
    localparam pattern_t PAT_OVER = '{beeps: 3'd4, on_ms: 10'd300, gap_ms: 10'd100};

    // Pattern table lookup by event index
    function automatic pattern_t pattern_lookup(input logic [1:0] idx);
        pattern_t pat;
        case (idx)
            EV_MOVE: pat = PAT_MOVE;
            EV_DROP: pat = PAT_DROP;
            EV_LINE: pat = PAT_LINE;
            default: pat = PAT_OVER;
        endcase
        return pat;
    endfunction

    // Index of the highest set bit (0 when nothing is set)
    function automatic logic [1:0] highest_pending(input logic [3:0] pend);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Event index to one-hot grant vector
    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : sound_pkg
`default_nettype wire

// File: rtl/ms_tick.sv
`default_nettype none
// ============================================================================
//  Module      : ms_tick
//  Description : 1 ms prescaler. Emits a one-cycle Tick every T1MS+1 enabled
//                cycles; the count is held at zero whenever En is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_tick #(
    parameter logic [15:0] T1MS = 16'd49_999
) (
    input  logic CLK,
    input  logic RST,
    input  logic En,
    output logic Tick
);

    logic [15:0] cnt_q;

    // Free-running 0..T1MS counter while enabled, parked at zero otherwise
    always_ff @(posedge CLK) begin
        if (RST || !En) begin
            cnt_q <= '0;
        end else if (cnt_q == T1MS) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign Tick = En && (cnt_q == T1MS);

endmodule : ms_tick
`default_nettype wire

// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sound_arbiter
//  Description : Buzzer sequencer. Latches one-cycle sound requests as pending
//                flags, plays the highest-priority one as a beep pattern and
//                lets game-over preempt any lower-priority pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_arbiter
    import sound_pkg::*;
#(
    parameter logic [15:0] T1MS = 16'd49_999
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Req,
    input  logic       Mute,
    output logic       Pin_Out,
    output logic [3:0] Grant,
    output logic       Busy,
    output logic       Done
);

    state_t     state_q;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [1:0] idx_q;
    logic [3:0] grant_q;
    logic [2:0] beep_q;
    logic [9:0] ms_q;
    logic       done_q;

    logic       tick;
    logic       busy_w;
    logic       preempt;
    logic [1:0] sel;
    logic [2:0] beep_inc;
    pattern_t   pat;

    assign busy_w   = (state_q != ST_IDLE);
    assign pat      = pattern_lookup(idx_q);
    assign sel      = highest_pending(pend_q);
    assign beep_inc = beep_q + 3'd1;
    // Game-over aborts anything except itself
    assign preempt  = Req[EV_OVER] && busy_w && (idx_q != EV_OVER);

    ms_tick #(
        .T1MS (T1MS)
    ) u_ms_tick (
        .CLK  (CLK),
        .RST  (RST),
        .En   (busy_w),
        .Tick (tick)
    );

    // Pending flags: new requests always set; a grant clears only its own bit,
    // so a request arriving on the grant cycle survives for a replay
    always_comb begin
        pend_d = pend_q | Req;
        if ((state_q == ST_IDLE) && (|pend_q)) begin
            pend_d = (pend_q & ~to_onehot(sel)) | Req;
        end
    end

    // Pattern sequencer: IDLE -> ON <-> GAP -> IDLE, with preemption to IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            beep_q  <= '0;
            ms_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|pend_q) begin
                        state_q <= ST_ON;
                        idx_q   <= sel;
                        grant_q <= to_onehot(sel);
                        beep_q  <= '0;
                        ms_q    <= '0;
                    end
                end
                ST_ON: begin
                    if (preempt) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ms_q    <= '0;
                    end else if (tick) begin
                        if (ms_q == pat.on_ms - 10'd1) begin
                            state_q <= ST_GAP;
                            ms_q    <= '0;
                        end else begin
                            ms_q <= ms_q + 10'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (preempt) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ms_q    <= '0;
                    end else if (tick) begin
                        if (ms_q == pat.gap_ms - 10'd1) begin
                            beep_q <= beep_inc;
                            ms_q   <= '0;
                            if (beep_inc < pat.beeps) begin
                                state_q <= ST_ON;
                            end else begin
                                state_q <= ST_IDLE;
                                grant_q <= '0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            ms_q <= ms_q + 10'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Mute only gates the pin; sequencing carries on regardless
    assign Pin_Out = (state_q == ST_ON) && !Mute;
    assign Grant   = grant_q;
    assign Busy    = busy_w;
    assign Done    = done_q;

endmodule : sound_arbiter
`default_nettype wire

// File: tb/tb_sound_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sound_arbiter
//  Description : Self-checking bench for sound_arbiter. A transaction-level
//                reference model predicts every output cycle into a queue; a
//                monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] Req;
    logic       Mute;
    logic       Pin_Out;
    logic [3:0] Grant;
    logic       Busy;
    logic       Done;

    sound_arbiter #(
        .T1MS (16'd9)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Req     (Req),
        .Mute    (Mute),
        .Pin_Out (Pin_Out),
        .Grant   (Grant),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference pattern table in cycles-per-ms = 10
    int BEEPS [4] = '{1, 1, 3, 4};
    int ON_MS [4] = '{20, 60, 100, 300};
    int GAP_MS[4] = '{20, 40, 50, 100};

    typedef struct {
        bit       tone;
        bit       busy;
        bit [3:0] grant;
        bit       done;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: what is playing and since which edge
    int       cyc    = 0;
    bit [3:0] m_pend = '0;
    bit       m_play = 1'b0;
    int       m_idx  = 0;
    int       m_start = 0;
    bit       m_done = 1'b0;

    function automatic int total_cycles(input int i);
        return BEEPS[i] * (ON_MS[i] + GAP_MS[i]) * 10;
    endfunction

    // Model: a playback is a time window; tone on/off follows from elapsed time
    always @(posedge CLK) begin
        exp_t e;
        int   el;
        int   hi;
        cyc++;
        if (RST) begin
            m_pend = '0;
            m_play = 1'b0;
            m_done = 1'b0;
        end else if (m_play) begin
            m_done = 1'b0;
            if (Req[3] && m_idx != 3) begin
                m_play = 1'b0;
            end else if (cyc - m_start == total_cycles(m_idx)) begin
                m_play = 1'b0;
                m_done = 1'b1;
            end
            m_pend = m_pend | Req;
        end else begin
            m_done = 1'b0;
            if (m_pend != 4'b0000) begin
                hi = -1;
                for (int i = 3; i >= 0; i--) begin
                    if (hi < 0 && m_pend[i]) hi = i;
                end
                m_idx   = hi;
                m_play  = 1'b1;
                m_start = cyc;
                m_pend[hi] = 1'b0;
            end
            m_pend = m_pend | Req;
        end
        el      = cyc - m_start;
        e.busy  = m_play;
        e.grant = m_play ? (4'b0001 << m_idx) : 4'b0000;
        e.done  = m_done;
        e.tone  = m_play && ((el % ((ON_MS[m_idx] + GAP_MS[m_idx]) * 10)) < ON_MS[m_idx] * 10);
        exp_q.push_back(e);
    end

    // Monitor: compare every predicted cycle against the DUT mid-cycle
    always @(negedge CLK) begin
        exp_t e;
        bit   pin_exp;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pin_exp = e.tone & ~Mute;
            n_chk++;
            if (Pin_Out !== pin_exp || Busy !== e.busy || Grant !== e.grant || Done !== e.done) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got pin=%b busy=%b grant=%b done=%b, expected pin=%b busy=%b grant=%b done=%b",
                         cyc, Pin_Out, Busy, Grant, Done, pin_exp, e.busy, e.grant, e.done);
            end
        end
    end

    // All drives happen 2 time units after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic pulse(input logic [3:0] r);
        Req = r;
        idle(1);
        Req = 4'b0000;
    endtask

    task automatic check_reset();
        n_chk++;
        if (Pin_Out !== 1'b0 || Busy !== 1'b0 || Grant !== 4'b0000 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: pin=%b busy=%b grant=%b done=%b",
                     Pin_Out, Busy, Grant, Done);
        end
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            idle(1);
            if (Done === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout: no Done within %0d cycles (cycle %0d)", max_cyc, cyc);
        end
    endtask

    initial begin
        RST  = 1'b1;
        Req  = 4'b0000;
        Mute = 1'b0;
        idle(3);
        check_reset();
        RST = 1'b0;
        idle(2);

        // Single short beep
        pulse(4'b0001);
        wait_done(450);
        idle(5);

        // Three-beep line clear
        pulse(4'b0100);
        wait_done(4600);
        idle(5);

        // Simultaneous requests: higher index first
        pulse(4'b0101);
        idle(5000);

        // Game over preempts line clear during its second beep
        pulse(4'b0100);
        idle(1700);
        pulse(4'b1000);
        idle(16050);

        // Muted piece drop
        Mute = 1'b1;
        pulse(4'b0010);
        idle(1050);
        Mute = 1'b0;
        idle(5);

        // Request coinciding with the grant cycle is kept for a replay
        pulse(4'b0010);
        pulse(4'b0010);
        idle(2100);

        // Repeated pulses while pending merge into one playback
        pulse(4'b0100);
        idle(50);
        pulse(4'b0001);
        idle(30);
        pulse(4'b0001);
        pulse(4'b0001);
        idle(5000);

        // Reset mid-ON with a pending request; requests during reset ignored
        pulse(4'b0001);
        idle(50);
        pulse(4'b0010);
        idle(20);
        RST = 1'b1;
        Req = 4'b0111;
        idle(2);
        Req = 4'b0000;
        RST = 1'b0;
        idle(500);

        // Randomised traffic with occasional mute changes and resets
        for (int c = 0; c < 20000; c++) begin
            logic [3:0] r;
            r = 4'b0000;
            if ($urandom_range(0, 199) == 0) begin
                r[2:0] = 3'($urandom_range(0, 7));
                r[3]   = ($urandom_range(0, 3) == 0);
            end
            Req = r;
            if ($urandom_range(0, 399) == 0) Mute = ~Mute;
            RST = ($urandom_range(0, 5999) == 0);
            idle(1);
        end
        Req = 4'b0000;
        RST = 1'b0;
        Mute = 1'b0;
        idle(20);

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_sound_arbiter
`default_nettype wire
